// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: forward-select encoding and standard producer latencies.
// Imported by the hazard unit and anything else that decodes forward selects.
package pipe_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;

endpackage

// File: rtl/sb_entry.sv
// One scoreboard slot: cycles remaining until a pending register write is forwardable.
// Load has priority over the decrement so the youngest writer always wins.
module sb_entry #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] loadVal,
  input  logic          dec,
  output logic [CW-1:0] cnt
);

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every slot samples pre-edge values.
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= loadVal;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding unit for the 5-stage core, driven by a per-register pending-write
// scoreboard so producers may take up to MAXLAT cycles; also handles data-memory freezes.
module hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int REGW   = 5,
  parameter int MAXLAT = 8,
  parameter int CW     = $clog2(MAXLAT + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [REGW-1:0] rsD,
  input  logic [REGW-1:0] rtD,
  input  logic            usesrsD,
  input  logic            usesrtD,
  input  logic            branchD,
  input  logic            regwriteD,
  input  logic [REGW-1:0] writeregD,
  input  logic [CW-1:0]   latD,
  input  logic            validD,
  input  logic [REGW-1:0] rsE,
  input  logic [REGW-1:0] rtE,
  input  logic [REGW-1:0] writeregM,
  input  logic [REGW-1:0] writeregW,
  input  logic            regwriteM,
  input  logic            regwriteW,
  input  logic            memreadyM,
  output logic            forwardaD,
  output logic            forwardbD,
  output logic [1:0]      forwardaE,
  output logic [1:0]      forwardbE,
  output logic            stallF,
  output logic            stallD,
  output logic            stallE,
  output logic            stallM,
  output logic            stallW,
  output logic            flushE,
  output logic [31:0]     stallcycles
);

  localparam int            NREG = 2 ** REGW;
  localparam logic [CW-1:0] MAXC = CW'(MAXLAT);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt [NREG];
  logic [CW-1:0] latClamped;
  logic [CW-1:0] cntRs;
  logic [CW-1:0] cntRt;
  logic          aluHaz;
  logic          brHaz;
  logic          hStall;
  logic          issue;
  logic [31:0]   stallCount;

  // r0 is hardwired to zero, so it can never be a pending write.
  assign cnt[0] = '0;

  assign latClamped = (latD > MAXC) ? MAXC : latD;
  assign cntRs      = cnt[rsD];
  assign cntRt      = cnt[rtD];

  // A count of 1 means the producer is in M next cycle: ALU consumers can forward from there,
  // but a D-stage branch compare cannot, so it waits one cycle longer.
  assign aluHaz = (usesrsD && cntRs > ONE) || (usesrtD && cntRt > ONE);
  assign brHaz  = branchD && ((usesrsD && cntRs >= ONE) || (usesrtD && cntRt >= ONE));
  assign hStall = validD && (aluHaz || brHaz);

  // A stalled or frozen D instruction has not really issued; latD of 0 records nothing.
  assign issue = validD && !hStall && memreadyM && regwriteD
              && writeregD != '0 && latD != '0;

  // NOTE: the scoreboard is plain flops rather than a RAM, so every slot is cleared on reset.
  for (genvar r = 1; r < NREG; r++) begin : g_entry
    sb_entry #(.CW(CW)) u_entry (
      .clk     (clk),
      .reset   (reset),
      .load    (issue && writeregD == REGW'(r)),
      .loadVal (latClamped),
      .dec     (memreadyM),
      .cnt     (cnt[r])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stallCount <= '0;
    end else if (hStall && memreadyM && stallCount != '1) begin
      stallCount <= stallCount + 32'd1;
    end
  end

  // The M bypass is checked first because it holds the younger value.
  function automatic fwd_sel_t fwdSel(input logic [REGW-1:0] src,
                                      input logic            wrM,
                                      input logic [REGW-1:0] dstM,
                                      input logic            wrW,
                                      input logic [REGW-1:0] dstW);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (src != '0 && wrM && src == dstM) begin
      sel = FWD_M;
    end else if (wrW && src == dstW) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

  always_comb begin
    // NOTE: every output gets a default first, so no branch can infer a latch.
    forwardaD   = 1'b0;
    forwardbD   = 1'b0;
    forwardaE   = FWD_RF;
    forwardbE   = FWD_RF;
    stallF      = 1'b0;
    stallD      = 1'b0;
    stallE      = 1'b0;
    stallM      = 1'b0;
    stallW      = 1'b0;
    flushE      = 1'b0;
    stallcycles = '0;
    if (!reset) begin
      forwardaD   = rsD != '0 && regwriteM && rsD == writeregM;
      forwardbD   = rtD != '0 && regwriteM && rtD == writeregM;
      forwardaE   = fwdSel(rsE, regwriteM, writeregM, regwriteW, writeregW);
      forwardbE   = fwdSel(rtE, regwriteM, writeregM, regwriteW, writeregW);
      stallcycles = stallCount;
      if (!memreadyM) begin
        // The memory freeze holds every stage in place; no bubble is created.
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        stallM = 1'b1;
        stallW = 1'b1;
      end else begin
        stallF = hStall;
        stallD = hStall;
        flushE = hStall;
      end
    end
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and forwarding unit for the 5-stage pipelined core. It replaces the fixed load/branch stall equations with a per-register pending-write scoreboard, so producers can have any result latency up to `MAXLAT`. It adds a whole-pipeline freeze for a data memory that is not ready, and a saturating stall-cycle counter. It sits beside the datapath and drives all forward selects, stalls and the E-stage flush.

## Interface
Parameters:
- `REGW`, 5, register index width; the unit tracks 2^REGW registers.
- `MAXLAT`, 8, maximum producer latency in cycles.
- `CW`, `$clog2(MAXLAT+1)`, latency and counter width.

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: reset is synchronous and active-high.
- `rsD`, `rtD` in REGW: D-stage source registers.
- `usesrsD`, `usesrtD` in 1: the D-stage instruction reads rs / rt.
- `branchD` in 1: the D-stage instruction compares in D.
- `regwriteD` in 1: the D-stage instruction writes a register.
- `writeregD` in REGW: destination register of the D-stage instruction.
- `latD` in CW: producer latency of the D-stage instruction.
- `validD` in 1: D holds a real instruction.
- `rsE`, `rtE` in REGW: E-stage source registers.
- `writeregM`, `writeregW` in REGW: M and W destination registers.
- `regwriteM`, `regwriteW` in 1: M and W write enables.
- `memreadyM` in 1: data memory is ready; 0 freezes the pipeline.
- `forwardaD`, `forwardbD` out 1: select `aluoutM` for the branch compare.
- `forwardaE`, `forwardbE` out 2: E-stage forward select: 00 = register file, 01 = `resultW`, 10 = `aluoutM`.
- `stallF`, `stallD`, `stallE`, `stallM`, `stallW` out 1: pipeline register enables, inverted.
- `flushE` out 1: inserts a bubble into E.
- `stallcycles` out 32: count of hazard stall cycles.

## Operation
- Scoreboard: one down-counter `cnt[r]` of width CW for each r in 1..2^REGW-1. Register 0 is never tracked; `cnt[0]` reads 0.
- Issue condition: `validD & ~stallD & memreadyM & regwriteD & writeregD != 0`.
  - On issue, `cnt[writeregD] <= min(latD, MAXLAT)`.
  - `latD = 0` records nothing.
  - An issue to a register with a nonzero count overwrites it, because the youngest writer wins.
- Decrement: every other nonzero counter decrements in every cycle with `memreadyM = 1`. This includes hazard stall cycles.
- ALU source hazard: `aluhaz = (usesrsD & cnt[rsD] > 1) | (usesrtD & cnt[rtD] > 1)`.
- Branch source hazard: `brhaz = branchD & ((usesrsD & cnt[rsD] >= 1) | (usesrtD & cnt[rtD] >= 1))`. A count of 0 means the result is in M (forwarded via `forwardaD`/`forwardbD`) or in W (write-through register file).
- Hazard stall: `hstall = validD & (aluhaz | brhaz)`.
- Freeze, when `memreadyM = 0`:
  - all five stalls are 1 and `flushE = 0`;
  - counters hold;
  - no issue is recorded.
- Otherwise:
  - `stallF = stallD = flushE = hstall`;
  - `stallE = stallM = stallW = 0`.
- E forwarding, per source: if the source ≠ 0, `regwriteM` is set and the source equals `writeregM`, select 10. Else, if `regwriteW` is set and the source equals `writeregW`, select 01. Else select 00.
- D forwarding: `forwardaD = rsD != 0 & regwriteM & rsD == writeregM`; `forwardbD` is the same using `rtD`.
- Producers with latency ≥ 3 assert `regwriteM`/`regwriteW` only in the cycle their result is valid on that bus.
- `stallcycles` increments when `hstall & memreadyM` and saturates at 32'hFFFF_FFFF.

## Timing
- `cnt` and `stallcycles` are registered. All other outputs are combinational from registered state and the current inputs; no added latency.
- A producer issued at edge t is seen with `cnt = latD` in cycle t+1.
  - A dependent ALU consumer stalls `latD - 1` cycles.
  - A dependent branch stalls `latD` cycles.
- Reset, including mid-operation:
  - all counters and `stallcycles` clear at the edge;
  - while `reset` is high, every output is forced to 0.
- An issue and a decrement of the same register in one cycle: the issue value wins.
- A freeze arriving during a hazard stall: the freeze dominates, and the hazard stall resumes with unchanged counts once `memreadyM = 1`.

## Structure
- Shared package `pipe_pkg`:
  - `fwd_sel_t` enum: `FWD_RF` = 2'b00, `FWD_W` = 2'b01, `FWD_M` = 2'b10;
  - `LAT_ALU` = 1 and `LAT_LOAD` = 2.
- One sub-module, `sb_entry`: a CW-bit down-counter with load, hold and synchronous clear. It is instantiated with a generate loop for registers 1..2^REGW-1.

## Test plan
- `add r8` issued with lat 1, then `sub` reading r8 → no stall; `forwardaE` = 10 on the next cycle.
- `lw r9` issued with lat 2, then `add` reading rt = r9 → `stallD` = `flushE` = 1 for exactly 1 cycle, then `forwardbE` = 01.
- ALU op writing r10, then `beq` on r10 → 1 stall, then `forwardaD` = 1. A load writing r10 followed by `beq` → 2 stalls, with `forwardaD` = 0 on release.
- Producer with lat 4 writing r11, then a consumer → exactly 3 stall cycles; `stallcycles` goes from 0 to 3.
- Load-use stall with `memreadyM` = 0 for 3 cycles → all stalls 1, `flushE` 0, `stallcycles` unchanged; after release, 1 more stall cycle.
- Issue with `writeregD` = 0 → no stall on a later r0 reader. Reset asserted with `cnt[r9]` = 2 → no stall on the next r9 reader and all outputs 0 during reset.
